log_frame_sequencer: RTL and testbench

//  Per-frame scheduler for the shared log stage of the MFCC pipeline. Accepts NUM_FILTERS mel-energy words
//  per frame from the filterbank and issues them in order to the log unit. Returns each result with its

---
 rtl/mfcc_pkg.sv | 10 +
 rtl/log_frame_sequencer_if.sv | 25 ++
 rtl/seq_result_fifo.sv | 37 +++
 rtl/log_frame_sequencer.sv | 86 ++++++++
 tb/tb_log_frame_sequencer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/mfcc_pkg.sv
// mfcc_pkg: shared constants and FSM encoding for the MFCC log-stage sequencer
package mfcc_pkg;
  localparam int NUM_FILTERS = 40;
  localparam int LOG_LAT = 3;
  localparam int RES_DEPTH = 4;
  localparam int DATA_W = 32;
  localparam int IDX_W = $clog2(NUM_FILTERS);
  localparam logic [DATA_W-1:0] LOG_FLOOR = 32'hFFFF_C000;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;
endpackage

// File: rtl/log_frame_sequencer_if.sv
// log_frame_sequencer_if: mel input, log-unit and coefficient handshakes of the log-stage sequencer
//   slave  : sequencer side (drives mel_ready, log_in*, coef_*, frame_done, busy)
//   master : environment side (filterbank, log unit, DCT stage, control)
interface log_frame_sequencer_if;
  import mfcc_pkg::*;
  logic              frame_start, abort;
  logic [DATA_W-1:0] mel_data;
  logic              mel_valid, mel_ready;
  logic [DATA_W-1:0] log_in;
  logic              log_in_valid;
  logic [DATA_W-1:0] log_res;
  logic              log_res_valid;
  logic [DATA_W-1:0] coef_data;
  logic [IDX_W-1:0]  coef_idx;
  logic              coef_valid, coef_ready, coef_last;
  logic              frame_done, busy;
  modport slave (
    input  frame_start, abort, mel_data, mel_valid, log_res, log_res_valid, coef_ready,
    output mel_ready, log_in, log_in_valid, coef_data, coef_idx, coef_valid, coef_last, frame_done, busy
  );
  modport master (
    output frame_start, abort, mel_data, mel_valid, log_res, log_res_valid, coef_ready,
    input  mel_ready, log_in, log_in_valid, coef_data, coef_idx, coef_valid, coef_last, frame_done, busy
  );
endinterface

// File: rtl/seq_result_fifo.sv
// seq_result_fifo: synchronous FIFO for {log result, filter index}
//   clk, rst (async, active-high), flush (sync clear), push/wdata, pop/rdata (head), cnt (occupancy)
//   Writer never pushes when full and reader never pops when empty; the credit scheme guarantees it.
module seq_result_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign rdata = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
endmodule

// File: rtl/log_frame_sequencer.sv
// log_frame_sequencer: per-frame scheduler feeding mel energies to the shared log unit
//   clk, rst (async, active-high); b: log_frame_sequencer_if.slave
//     mel_*  : filterbank input, back-pressured outside RUN or without credit
//     log_*  : registered issue to the log unit, fixed-latency results back
//     coef_* : indexed results to the DCT stage from the result FIFO head
//     frame_start/abort/frame_done/busy : frame control
//   Optional macro LOG_FLOOR_EN: zero-energy inputs yield LOG_FLOOR instead of the log result.
module log_frame_sequencer
  import mfcc_pkg::*;
(
  input logic clk,
  input logic rst,
  log_frame_sequencer_if.slave b
);
  localparam int ICW = $clog2(NUM_FILTERS + 1);
  localparam int CW = $clog2(LOG_LAT + 2);
  localparam int FW = $clog2(RES_DEPTH) + 1;
  seq_state_t state, state_nxt;
  logic [ICW-1:0] issue_cnt;
  logic [IDX_W-1:0] ret_idx;
  logic [CW-1:0] inflight, drop_cnt;
  logic [FW-1:0] fifo_cnt;
  logic [DATA_W-1:0] log_in, res_word;
  logic [DATA_W+IDX_W-1:0] head;
  logic log_in_valid, start, issue, ret_raw, ret, drop, credit;
  // A result slot is reserved from issue until it leaves the FIFO, so pushes never overflow.
  assign credit = int'(fifo_cnt) + int'(inflight) < RES_DEPTH;
  assign b.mel_ready = state == RUN && credit && issue_cnt < ICW'(NUM_FILTERS);
  assign start = state == IDLE && b.frame_start && drop_cnt == '0;
  assign issue = b.mel_valid && b.mel_ready && !b.abort;
  assign drop = b.log_res_valid && drop_cnt != '0;
  assign ret_raw = b.log_res_valid && drop_cnt == '0 && inflight != '0;
  assign ret = ret_raw && !b.abort;
`ifdef LOG_FLOOR_EN
  // Zero flag rides alongside the registered operand, so LOG_LAT stages line it up with log_res.
  logic [LOG_LAT-1:0] zero_pipe;
  always_ff @(posedge clk or posedge rst)
    if (rst) zero_pipe <= '0;
    else zero_pipe <= LOG_LAT'({zero_pipe, log_in_valid && log_in == '0});
  assign res_word = zero_pipe[LOG_LAT-1] ? LOG_FLOOR : b.log_res;
`else
  assign res_word = b.log_res;
`endif
  seq_result_fifo #(.W(DATA_W + IDX_W), .DEPTH(RES_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .flush(b.abort), .push(ret), .pop(b.coef_valid && b.coef_ready),
    .wdata({res_word, ret_idx}), .rdata(head), .cnt(fifo_cnt)
  );
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? RUN : IDLE;
      RUN:     state_nxt = issue && issue_cnt == ICW'(NUM_FILTERS - 1) ? DRAIN : RUN;
      DRAIN:   state_nxt = inflight == '0 && fifo_cnt == '0 ? DONE : DRAIN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (b.abort) state_nxt = IDLE;
  end
  // On abort, results already in the log pipe are counted out by drop_cnt instead of pushed.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      issue_cnt <= '0;
      ret_idx <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      log_in <= '0;
      log_in_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      issue_cnt <= b.abort || start ? '0 : issue_cnt + ICW'(issue);
      ret_idx <= b.abort || start ? '0 : ret_idx + IDX_W'(ret);
      inflight <= b.abort ? '0 : inflight + CW'(issue) - CW'(ret);
      drop_cnt <= drop_cnt - CW'(drop) + (b.abort ? inflight - CW'(ret_raw) : '0);
      log_in_valid <= issue;
      if (issue) log_in <= b.mel_data;
    end
  assign b.log_in = log_in;
  assign b.log_in_valid = log_in_valid;
  assign b.coef_valid = fifo_cnt != '0;
  assign b.coef_data = b.coef_valid ? head[DATA_W+IDX_W-1:IDX_W] : '0;
  assign b.coef_idx = b.coef_valid ? head[IDX_W-1:0] : '0;
  assign b.coef_last = b.coef_valid && b.coef_idx == IDX_W'(NUM_FILTERS - 1);
  assign b.frame_done = state == DONE;
  assign b.busy = state != IDLE;
endmodule

// File: tb/tb_log_frame_sequencer.sv
// tb_log_frame_sequencer: directed self-checking bench with a fixed-latency log-unit model
module tb_log_frame_sequencer;
  logic clk = 1'b0;
  logic rst;
  int vec = 0;
  int errs = 0;
  int cyc = 0;
  int done_cnt = 0;
  int nres = 0;
  int acc_cyc[$];
  int pop_cyc[$];
  logic [31:0] got_data[$];
  logic [5:0] got_idx[$];
  logic got_last[$];
  logic [2:0] lp_v = '0;
  logic [31:0] lp_d [3];
  log_frame_sequencer_if bus ();
  log_frame_sequencer dut (.clk(clk), .rst(rst), .b(bus));
  always #5 clk = ~clk;
  // log unit: result = operand + 0x100, exactly 3 cycles after log_in_valid; not reset
  always @(posedge clk) begin
    lp_v <= {lp_v[1:0], bus.log_in_valid};
    lp_d[0] <= bus.log_in + 32'h100;
    lp_d[1] <= lp_d[0];
    lp_d[2] <= lp_d[1];
  end
  assign bus.log_res_valid = lp_v[2];
  assign bus.log_res = lp_d[2];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mel_valid && bus.mel_ready) acc_cyc.push_back(cyc);
    if (bus.coef_valid && bus.coef_ready) begin
      got_data.push_back(bus.coef_data);
      got_idx.push_back(bus.coef_idx);
      got_last.push_back(bus.coef_last);
      pop_cyc.push_back(cyc);
    end
    if (bus.frame_done) done_cnt <= done_cnt + 1;
    if (bus.log_res_valid) nres <= nres + 1;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] wv(input int base, input int i, input int zi);
    return (i == zi) ? 32'h0 : 32'(base + i * 17);
  endfunction
  function automatic logic [31:0] ev(input int base, input int i, input int zi);
    logic [31:0] w = wv(base, i, zi);
`ifdef LOG_FLOOR_EN
    if (w == 32'h0) return 32'hFFFF_C000;
`endif
    return w + 32'h100;
  endfunction
  task automatic pulse_start();
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask
  task automatic feed(input int ab, input int n, input int base, input int zi, input int maxc);
    int t = 0;
    while (acc_cyc.size() - ab < n && t < maxc) begin
      bus.mel_valid = 1'b1;
      bus.mel_data = wv(base, acc_cyc.size() - ab, zi);
      @(negedge clk);
      t++;
    end
    bus.mel_valid = 1'b0;
  endtask
  task automatic wait_done(input int d0, input string tag);
    int t = 0;
    while (done_cnt == d0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 64'(done_cnt - d0), 64'd1);
  endtask
  task automatic check_frame(input int qb, input int base, input int zi, input string tag);
    chk({tag, "_count"}, 64'(got_data.size() - qb), 64'd40);
    for (int i = 0; i < 40; i++)
      if (qb + i < got_data.size()) begin
        chk({tag, "_idx"}, 64'(got_idx[qb+i]), 64'(i));
        chk({tag, "_data"}, 64'(got_data[qb+i]), 64'(ev(base, i, zi)));
        chk({tag, "_last"}, 64'(got_last[qb+i]), 64'(i == 39));
      end
  endtask
  initial begin
    int qb, ab, d0, n0, seen;
    rst = 1'b1;
    bus.frame_start = 1'b0;
    bus.abort = 1'b0;
    bus.mel_valid = 1'b0;
    bus.mel_data = '0;
    bus.coef_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_mel_ready", 64'(bus.mel_ready), 64'd0);
    chk("rst_coef_valid", 64'(bus.coef_valid), 64'd0);
    chk("rst_log_in_valid", 64'(bus.log_in_valid), 64'd0);
    chk("rst_frame_done", 64'(bus.frame_done), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    // 1: full frame, streaming
    qb = got_data.size(); ab = acc_cyc.size(); d0 = done_cnt;
    pulse_start();
    chk("t1_busy", 64'(bus.busy), 64'd1);
    feed(ab, 40, 'h1000, -1, 400);
    wait_done(d0, "t1_done");
    repeat (3) @(negedge clk);
    chk("t1_done_once", 64'(done_cnt - d0), 64'd1);
    chk("t1_busy_after", 64'(bus.busy), 64'd0);
    check_frame(qb, 'h1000, -1, "t1");
    if (pop_cyc.size() > qb) chk("t1_latency", 64'(pop_cyc[qb] - acc_cyc[ab]), 64'd5);
    // 2: stalled DCT stage, then release; frame_start in RUN ignored
    bus.coef_ready = 1'b0;
    qb = got_data.size(); ab = acc_cyc.size(); d0 = done_cnt;
    pulse_start();
    feed(ab, 40, 'h2000, -1, 30);
    chk("t2_issued", 64'(acc_cyc.size() - ab), 64'd4);
    chk("t2_mel_ready", 64'(bus.mel_ready), 64'd0);
    chk("t2_coef_valid", 64'(bus.coef_valid), 64'd1);
    chk("t2_head_idx", 64'(bus.coef_idx), 64'd0);
    pulse_start();
    repeat (5) @(negedge clk);
    chk("t2_busy", 64'(bus.busy), 64'd1);
    chk("t2_issued_hold", 64'(acc_cyc.size() - ab), 64'd4);
    bus.coef_ready = 1'b1;
    feed(ab, 40, 'h2000, -1, 400);
    wait_done(d0, "t2_done");
    check_frame(qb, 'h2000, -1, "t2");
    // 3: abort after 20 issues; in-pipe results dropped; restart at idx 0
    ab = acc_cyc.size(); d0 = done_cnt;
    pulse_start();
    feed(ab, 20, 'h5000, -1, 200);
    chk("t3_issued", 64'(acc_cyc.size() - ab), 64'd20);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("t3_busy", 64'(bus.busy), 64'd0);
    chk("t3_fifo_empty", 64'(bus.coef_valid), 64'd0);
    n0 = nres; seen = 0;
    repeat (8) begin
      @(negedge clk);
      seen |= int'(bus.coef_valid);
    end
    chk("t3_results_arrived", 64'(nres > n0), 64'd1);
    chk("t3_no_push", 64'(seen), 64'd0);
    chk("t3_no_done", 64'(done_cnt - d0), 64'd0);
    qb = got_data.size(); ab = acc_cyc.size(); d0 = done_cnt;
    pulse_start();
    feed(ab, 40, 'h3000, -1, 400);
    wait_done(d0, "t3_done");
    check_frame(qb, 'h3000, -1, "t3");
    // 4: mel_valid while IDLE is back-pressured
    ab = acc_cyc.size();
    bus.mel_valid = 1'b1;
    bus.mel_data = 32'h1234;
    repeat (4) @(negedge clk);
    chk("t4_mel_ready", 64'(bus.mel_ready), 64'd0);
    chk("t4_log_in_valid", 64'(bus.log_in_valid), 64'd0);
    chk("t4_no_accept", 64'(acc_cyc.size() - ab), 64'd0);
    bus.mel_valid = 1'b0;
    // 5: zero energy at filter 7
    qb = got_data.size(); ab = acc_cyc.size(); d0 = done_cnt;
    pulse_start();
    feed(ab, 40, 'h4000, 7, 400);
    wait_done(d0, "t5_done");
    check_frame(qb, 'h4000, 7, "t5");
    // 6: reset in DRAIN; stale results afterwards are ignored
    ab = acc_cyc.size(); d0 = done_cnt;
    pulse_start();
    feed(ab, 40, 'h6000, -1, 400);
    rst = 1'b1;
    #1;
    chk("t6_busy", 64'(bus.busy), 64'd0);
    chk("t6_mel_ready", 64'(bus.mel_ready), 64'd0);
    chk("t6_log_in_valid", 64'(bus.log_in_valid), 64'd0);
    chk("t6_log_in", 64'(bus.log_in), 64'd0);
    chk("t6_coef_valid", 64'(bus.coef_valid), 64'd0);
    chk("t6_coef_data", 64'(bus.coef_data), 64'd0);
    chk("t6_coef_idx", 64'(bus.coef_idx), 64'd0);
    chk("t6_coef_last", 64'(bus.coef_last), 64'd0);
    chk("t6_frame_done", 64'(bus.frame_done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n0 = nres; seen = 0;
    repeat (8) begin
      @(negedge clk);
      seen |= int'(bus.coef_valid);
    end
    chk("t6_stale_arrived", 64'(nres > n0), 64'd1);
    chk("t6_no_push", 64'(seen), 64'd0);
    chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
    qb = got_data.size(); ab = acc_cyc.size(); d0 = done_cnt;
    pulse_start();
    feed(ab, 40, 'h7000, -1, 400);
    wait_done(d0, "t6_done");
    check_frame(qb, 'h7000, -1, "t6");
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
